// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Data-side memory slave for the load/store path. Word-organised
//           single-port RAM with byte strobes and programmable read/write
//           wait states, driven by one shared request FSM.
// Config  : DATA_MEM_ERR_EN - when defined, accesses at or above
//           DEPTH_WORDS*4 raise err, suppress the write and return rdata=0.
//           When undefined, upper address bits are ignored (aliasing).
// Revision: 1.1 - RAM left uninitialised at elaboration
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1,
    parameter     INIT_FILE     = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    // read channel
    input  logic        re_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    // write channel
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        wdone_o,
    // status
    output logic        busy_o,
    output logic        err_o
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            oor_q, oor_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     rdata_q;
    logic            rvalid_q, rvalid_d;
    logic            wdone_q, wdone_d;
    logic            err_q, err_d;
    logic            rd_fire;
    logic            mem_we;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Word index taken straight from the bus; byte offset is the master's job.
    logic [AW-1:0]   widx, ridx;
    logic            woor, roor;
    logic            unused_addr;

    assign widx = waddr_i[AW+1:2];
    assign ridx = raddr_i[AW+1:2];
    assign unused_addr = ^{raddr_i, waddr_i};

`ifdef DATA_MEM_ERR_EN
    assign woor = ((waddr_i >> (AW + 2)) != 32'd0);
    assign roor = ((raddr_i >> (AW + 2)) != 32'd0);
`else
    assign woor = 1'b0;
    assign roor = 1'b0;
`endif

    // Next-state logic: accept only in IDLE, write wins over read, one RESP cycle per access.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        err_d    = 1'b0;
        rd_fire  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (we_i) begin
                    state_d = WR_WAIT;
                    cnt_d   = WR_LOAD;
                    idx_d   = widx;
                    oor_d   = woor;
                    wdata_d = wdata_i;
                    wstrb_d = wstrb_i;
                end else if (re_i) begin
                    state_d = RD_WAIT;
                    cnt_d   = RD_LOAD;
                    idx_d   = ridx;
                    oor_d   = roor;
                end
            end
            RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rd_fire  = 1'b1;
                    rvalid_d = 1'b1;
                    err_d    = oor_q;
                    state_d  = RESP;
                end
            end
            WR_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    mem_we  = ~oor_q;
                    wdone_d = 1'b1;
                    err_d   = oor_q;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control/state registers; a reset before the commit edge simply abandons the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
        end
    end

    // Read data register: updated only when a read completes, zero on a faulting read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_fire) begin
            rdata_q <= oor_q ? 32'd0 : mem_q[idx_q];
        end
    end

    // RAM write port with per-byte enables; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign wdone_o  = wdone_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Self-checking bench for data_mem_responder. Three instances with
//           different wait-state settings share clock and reset:
//             A: RL=1 WL=1 depth 1024 (table-driven vectors)
//             B: RL=3 WL=2 depth 64   (long latency, write+read collision)
//             C: RL=1 WL=4 depth 64   (reset during a pending write)
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

`ifdef DATA_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        re     [3];
  logic        we     [3];
  logic [31:0] raddr  [3];
  logic [31:0] waddr  [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wstrb  [3];
  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        wdone  [3];
  logic        busy   [3];
  logic        err    [3];

  int rl_c [3] = '{1, 3, 1};
  int wl_c [3] = '{1, 2, 4};

  int n_vec = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .re_i(re[0]), .raddr_i(raddr[0]), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]),
    .we_i(we[0]), .waddr_i(waddr[0]), .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .wdone_o(wdone[0]),
    .busy_o(busy[0]), .err_o(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .READ_LATENCY(3), .WRITE_LATENCY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .re_i(re[1]), .raddr_i(raddr[1]), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]),
    .we_i(we[1]), .waddr_i(waddr[1]), .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .wdone_o(wdone[1]),
    .busy_o(busy[1]), .err_o(err[1])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .READ_LATENCY(1), .WRITE_LATENCY(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .re_i(re[2]), .raddr_i(raddr[2]), .rdata_o(rdata[2]), .rvalid_o(rvalid[2]),
    .we_i(we[2]), .waddr_i(waddr[2]), .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .wdone_o(wdone[2]),
    .busy_o(busy[2]), .err_o(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus access on instance d, started at a negedge with the DUT idle.
  // lat = cycles from accept edge to pulse (-1 on timeout).
  task automatic access(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output bit er, output int lat,
                        output bit busy_ok);
    bit seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = -1;
    rd      = '0;
    er      = 1'b0;
    if (wr) begin
      we[d] = 1'b1; waddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
    end else begin
      re[d] = 1'b1; raddr[d] = addr;
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (!busy[d]) busy_ok = 1'b0;
      if (wr ? wdone[d] : rvalid[d]) begin
        seen = 1'b1;
        lat  = k - 1;
        rd   = rdata[d];
        er   = err[d];
      end
    end
    we[d] = 1'b0;
    re[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] last_rd;
    bit          er;
    bit          bok;
    int          lat;
    int          wd_k;
    int          rv_k;
    logic [31:0] rv_data;

    for (int d = 0; d < 3; d++) begin
      re[d] = 0; we[d] = 0; raddr[d] = '0; waddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: every output low for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk($sformatf("idle_d%0d_c%0d", d, c),
            {rdata[d][27:0], rvalid[d], wdone[d], busy[d], err[d]} | {28'd0, 4'd0} | 32'(rdata[d] != 0),
            32'd0);
    end

    // Table-driven sequence on instance A.
    vecs.push_back(vec_t'{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h14,   32'h11223344, 4'hF, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h14,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h14,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h14,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h18,   32'h55667788, 4'hF, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h1A,   32'h000000AA, 4'h1, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h1B,   32'h0,        4'h0, 32'h556677AA, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b1, 32'hFFF,  32'h01020304, 4'hF, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h01020304, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h1000, 32'h99999999, 4'hF, 32'h0,        ERR_EN});
    vecs.push_back(vec_t'{1'b0, 32'h0,    32'h0,        4'h0,
                          ERR_EN ? 32'hCAFEF00D : 32'h99999999, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h1000, 32'h0,        4'h0,
                          ERR_EN ? 32'h00000000 : 32'h99999999, ERR_EN});
    vecs.push_back(vec_t'{1'b1, 32'h20,   32'h00000001, 4'hF, 32'h0,        1'b0});

    last_rd = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      access(0, vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, er, lat, bok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].is_wr ? wl_c[0] : rl_c[0]));
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      if (!vecs[i].is_wr) begin
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        last_rd = vecs[i].exp_rdata;
      end
    end
    chk("rdata_hold_a", rdata[0], last_rd);

    // Instance B: long wait states.
    access(1, 1'b1, 32'h24, 32'h00000077, 4'hF, rd, er, lat, bok);
    chk("b_wr_latency", 32'(lat), 32'd2);
    access(1, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat, bok);
    chk("b_rd_latency", 32'(lat), 32'd3);
    chk("b_rd_busy", 32'(bok), 32'd1);
    chk("b_rd_data", rd, 32'h00000077);

    // Instance B: write and read raised together on the same word.
    we[1] = 1'b1; re[1] = 1'b1; waddr[1] = 32'h20; raddr[1] = 32'h20;
    wdata[1] = 32'h5; wstrb[1] = 4'hF;
    wd_k = -1; rv_k = -1; rv_data = '0;
    for (int k = 1; k <= 30 && rv_k < 0; k++) begin
      @(negedge clk);
      if (wdone[1] && wd_k < 0) begin
        wd_k  = k;
        we[1] = 1'b0;
      end
      if (rvalid[1]) begin
        rv_k    = k;
        rv_data = rdata[1];
        re[1]   = 1'b0;
      end
    end
    we[1] = 1'b0; re[1] = 1'b0;
    @(negedge clk);
    chk("b_coll_wdone_cycle", 32'(wd_k), 32'd3);
    chk("b_coll_rvalid_cycle", 32'(rv_k), 32'd8);
    chk("b_coll_rdata", rv_data, 32'h5);

    // Instance C: reset lands while a write is still counting down.
    access(2, 1'b1, 32'h8, 32'h12345678, 4'hF, rd, er, lat, bok);
    chk("c_wr_latency", 32'(lat), 32'd4);
    access(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, bok);
    chk("c_rd_data", rd, 32'h12345678);
    we[2] = 1'b1; waddr[2] = 32'h8; wdata[2] = 32'hFFFFFFFF; wstrb[2] = 4'hF;
    repeat (2) @(negedge clk);
    chk("c_busy_before_rst", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("c_busy_in_rst", 32'(busy[2]), 32'd0);
    chk("c_rdata_in_rst", rdata[2], 32'd0);
    we[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wd_k = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wdone[2]) wd_k++;
    end
    chk("c_no_wdone_after_rst", 32'(wd_k), 32'd0);
    access(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, bok);
    chk("c_word_intact", rd, 32'h12345678);
    chk("c_rd_latency", 32'(lat), 32'd1);

    // RAM survives reset on instance A too.
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bok);
    chk("a_ram_after_rst", rd, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
